// File: rtl/pong_uart_cmd_decoder.sv
// Turns received UART ASCII bytes into Pong game control: start/reset pulses,
// PLAY/PAUSE state and four held paddle levels that bridge keyboard autorepeat gaps.
module pong_uart_cmd_decoder #(
  parameter int HOLD_CLKS = 15000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Game_Start,
  output logic       o_Game_Reset,
  output logic       o_Game_Active,
  output logic       o_Paused,
  output logic       o_Paddle_Up_P1,
  output logic       o_Paddle_Dn_P1,
  output logic       o_Paddle_Up_P2,
  output logic       o_Paddle_Dn_P2,
  output logic       o_Bad_Cmd
);

  localparam int CW = $clog2(HOLD_CLKS + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CLKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_IGNORE = 3'd0,
    CMD_START  = 3'd1,
    CMD_PAUSE  = 3'd2,
    CMD_RESET  = 3'd3,
    CMD_PADDLE = 3'd4,
    CMD_BAD    = 3'd5
  } cmd_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic               reset_q, reset_d;
  logic               bad_q, bad_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;

  cmd_t       cmd;
  logic [1:0] paddle_idx;
  logic [1:0] paddle_opp;

  // Paddle index: bit1 selects player, bit0 selects direction (0 = up, 1 = down).
  always_comb begin
    cmd        = CMD_BAD;
    paddle_idx = 2'd0;
    case (i_RX_Byte)
      8'h53, 8'h73, 8'h20: cmd = CMD_START;
      8'h50, 8'h70:        cmd = CMD_PAUSE;
      8'h52, 8'h72:        cmd = CMD_RESET;
      8'h57, 8'h77: begin cmd = CMD_PADDLE; paddle_idx = 2'd0; end
      8'h58, 8'h78: begin cmd = CMD_PADDLE; paddle_idx = 2'd1; end
      8'h49, 8'h69: begin cmd = CMD_PADDLE; paddle_idx = 2'd2; end
      8'h4D, 8'h6D: begin cmd = CMD_PADDLE; paddle_idx = 2'd3; end
      8'h0D, 8'h0A:        cmd = CMD_IGNORE;
      default:             cmd = CMD_BAD;
    endcase
    paddle_opp = {paddle_idx[1], ~paddle_idx[0]};
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    reset_d = 1'b0;
    bad_d   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
    end

    if (i_RX_DV) begin
      case (cmd)
        CMD_START: begin
          if (state_q == IDLE) begin
            state_d = PLAY;
            start_d = 1'b1;
          end
        end
        CMD_PAUSE: begin
          if (state_q == PLAY) begin
            state_d = PAUSE;
            cnt_d   = '0;
          end else if (state_q == PAUSE) begin
            state_d = PLAY;
          end
        end
        CMD_RESET: begin
          if (state_q != IDLE) begin
            state_d = IDLE;
            reset_d = 1'b1;
            cnt_d   = '0;
          end
        end
        CMD_PADDLE: begin
          // Loading one direction kills the other so a player never drives both.
          if (state_q != PAUSE) begin
            cnt_d[paddle_idx] = HOLD_LOAD;
            cnt_d[paddle_opp] = '0;
          end
        end
        CMD_BAD:    bad_d = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      reset_q <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      reset_q <= reset_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Game_Start   = start_q;
  assign o_Game_Reset   = reset_q;
  assign o_Bad_Cmd      = bad_q;
  assign o_Game_Active  = (state_q == PLAY);
  assign o_Paused       = (state_q == PAUSE);
  assign o_Paddle_Up_P1 = (cnt_q[0] != '0);
  assign o_Paddle_Dn_P1 = (cnt_q[1] != '0);
  assign o_Paddle_Up_P2 = (cnt_q[2] != '0);
  assign o_Paddle_Dn_P2 = (cnt_q[3] != '0);

endmodule

// File: doc/pong_uart_cmd_decoder.md
Name: pong_uart_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver (115200 baud, 25 MHz) and upstream of the Pong game core.
- Turns received ASCII bytes into a registered game-start pulse, a game-reset pulse, a pause state and four held paddle-control levels.
- This lets a PC keyboard drive the game alongside, or instead of, the debounced push buttons.

Parameters:
- HOLD_CLKS, 15000000, clocks a paddle output stays asserted after its last key byte (600 ms at 25 MHz; bridges keyboard autorepeat gaps).

Ports:
- i_Clk  in  1  system clock, 25 MHz
- i_Rst_L  in  1  asynchronous reset, active low
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte valid
- i_RX_Byte  in  8  received ASCII byte
- o_Game_Start  out  1  one-cycle pulse: game start
- o_Game_Reset  out  1  one-cycle pulse: return to idle
- o_Game_Active  out  1  high while in PLAY
- o_Paused  out  1  high while in PAUSE
- o_Paddle_Up_P1  out  1  held level
- o_Paddle_Dn_P1  out  1  held level
- o_Paddle_Up_P2  out  1  held level
- o_Paddle_Dn_P2  out  1  held level
- o_Bad_Cmd  out  1  one-cycle pulse: unrecognised byte

Behaviour:
- Single clock i_Clk. Reset is asynchronous, active-low on i_Rst_L.
- Reset values:
  - state = IDLE
  - all outputs 0
  - all four hold counters 0
- Byte decode is case-insensitive:
  - 'S'/'s' or space (0x20) = START
  - 'P'/'p' = PAUSE
  - 'R'/'r' = RESET
  - 'W'/'w' = P1 up; 'X'/'x' = P1 down
  - 'I'/'i' = P2 up; 'M'/'m' = P2 down
  - CR (0x0D) and LF (0x0A) are ignored silently.
  - Any other byte pulses o_Bad_Cmd for 1 cycle; state and counters are unchanged.
- Latency: all effects are registered and visible on the cycle after i_RX_DV is sampled high. Bytes are only consumed when i_RX_DV=1.
- State machine:
  - IDLE + START -> PLAY, o_Game_Start=1 for 1 cycle.
  - PLAY + PAUSE -> PAUSE.
  - PAUSE + PAUSE -> PLAY. No start pulse.
  - PLAY or PAUSE + RESET -> IDLE, o_Game_Reset=1 for 1 cycle.
  - RESET in IDLE: ignored, no pulse.
  - START in PLAY or PAUSE: ignored, not flagged as bad.
  - PAUSE in IDLE: ignored.
- Output decode:
  - o_Game_Active = (state==PLAY).
  - o_Paused = (state==PAUSE).
  - Both are registered, updating on the same cycle as the transition.
- Paddle hold counters:
  - One counter per output, width $clog2(HOLD_CLKS+1).
  - A matching key in IDLE or PLAY loads its counter with HOLD_CLKS.
  - The same key also clears the opposite-direction counter of the same player in the same cycle; opposite directions are never both high.
  - Counters not loaded or cleared decrement by 1 when nonzero and saturate at 0.
  - Output = (counter != 0). A single key gives exactly HOLD_CLKS high cycles.
  - A repeat key before expiry reloads the counter, keeping the output continuously high.
- Entering PAUSE or IDLE (via RESET) clears all four counters in the transition cycle. Outputs drop to 0 the next cycle.
- Paddle keys received while in PAUSE are ignored; they are not flagged as bad.
- Player 1 and player 2 counters are independent.
- Asserting i_Rst_L low mid-hold or mid-pulse forces every output to 0 immediately (asynchronous). Operation resumes from IDLE on the first clock after release.

Test Plan (HOLD_CLKS=8 in bench):
- Reset, then DV with 0x53 ('S') -> o_Game_Start high exactly 1 cycle, 1 cycle after DV; o_Game_Active=1 thereafter. A second 's' gives no pulse and o_Bad_Cmd=0.
- In PLAY, DV 'w' -> o_Paddle_Up_P1 high exactly 8 cycles. DV 'W' again at cycle 5 -> high continuously for 5+8=13 cycles total.
- In PLAY, DV 'w', then 3 cycles later DV 'x' -> Up_P1 falls and Dn_P1 rises on the same edge; Dn_P1 stays high 8 cycles; never both high.
- In PLAY with Up_P2 held, DV 'p' -> o_Paused=1, o_Game_Active=0, Up_P2=0 the next cycle. DV 'i' while paused -> no output change. DV 'P' -> back to PLAY, no start pulse.
- DV 0x7A ('z') -> o_Bad_Cmd single pulse. DV 0x0D -> no pulse. In PLAY, DV 'r' -> o_Game_Reset pulse and o_Game_Active=0; a further 'r' in IDLE -> nothing.
- Assert i_Rst_L low between clock edges while a paddle output is high and in PLAY -> all outputs 0 before the next edge. After release, a 'p' is ignored (IDLE) and an 's' starts the game.
